// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops DATA_WIDTH-bit words from a show-ahead FIFO and sends
// them as consecutive 8N1 UART frames, least-significant byte first.
// Optional build macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit
// after the data bits of every byte (8E1 frames).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_stb,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic [7:0]            o_word_count
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_n;
  logic [CNT_W-1:0]      clk_cnt_r, clk_cnt_n;
  logic [2:0]            bit_idx_r, bit_idx_n;
  logic [BYTE_W-1:0]     byte_idx_r, byte_idx_n;
  logic [7:0]            count_r, count_n;
  logic                  tx_r, tx_n;
  logic                  busy_r;
  logic                  pop_s;
  logic                  bit_done_s;

`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_r;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  assign bit_done_s    = (clk_cnt_r == LAST_CNT);
  assign o_fifo_rd_stb = pop_s;
  assign o_tx          = tx_r;
  assign o_busy        = busy_r;
  assign o_word_count  = count_r;

  // Next-state, datapath and line-value decode for the transmit FSM.
  always_comb begin
    state_n    = state_r;
    shreg_n    = shreg_r;
    bit_idx_n  = bit_idx_r;
    byte_idx_n = byte_idx_r;
    count_n    = count_r;
    pop_s      = 1'b0;
    tx_n       = 1'b1;

    // Bit-period counter restarts at every bit boundary, so bytes never drift.
    if (state_r == IDLE) begin
      clk_cnt_n = {CNT_W{1'b0}};
    end else if (bit_done_s) begin
      clk_cnt_n = {CNT_W{1'b0}};
    end else begin
      clk_cnt_n = clk_cnt_r + CNT_W'(1);
    end

    case (state_r)
      IDLE: begin
        // Pop is gated by reset so nothing leaves the FIFO while held in reset.
        if (i_reset_n && i_enable && !i_fifo_empty) begin
          pop_s      = 1'b1;
          shreg_n    = i_fifo_data;
          byte_idx_n = {BYTE_W{1'b0}};
          bit_idx_n  = 3'd0;
          state_n    = START;
        end else begin
          state_n    = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          state_n   = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          // Shifting right walks through the byte and leaves the next byte in [7:0].
          shreg_n = {1'b0, shreg_r[DATA_WIDTH-1:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_n = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx_r + 3'd1;
            state_n   = DATA;
          end
        end else begin
          state_n = DATA;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          state_n = STOP;
        end else begin
          state_n = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_done_s) begin
          if (byte_idx_r == LAST_BYTE) begin
            count_n = count_r + 8'd1;
            state_n = IDLE;
          end else begin
            byte_idx_n = byte_idx_r + BYTE_W'(1);
            state_n    = START;
          end
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Line value for the coming cycle is derived from where the FSM is going.
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_n = par_r;
`endif
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  // State, datapath and registered outputs; reset abandons any word in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= IDLE;
      shreg_r    <= {DATA_WIDTH{1'b0}};
      clk_cnt_r  <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      byte_idx_r <= {BYTE_W{1'b0}};
      count_r    <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      shreg_r    <= shreg_n;
      clk_cnt_r  <= clk_cnt_n;
      bit_idx_r  <= bit_idx_n;
      byte_idx_r <= byte_idx_n;
      count_r    <= count_n;
      tx_r       <= tx_n;
      busy_r     <= (state_n != IDLE);
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Capture the parity of the current byte while its start bit is on the line.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      par_r <= 1'b0;
    end else if ((state_r == START) && bit_done_s) begin
      par_r <= even_parity(shreg_r[7:0]);
    end else begin
      par_r <= par_r;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx (16-bit words, 4 clocks/bit).
// Honors FIFO_UART_TX_PARITY_EN so the same bench covers both builds.
module tb_fifo_uart_tx;

  localparam int DW  = 16;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int PITCH = 2 * F * CPB + 1;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_enable;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_rd_stb;
  logic          o_tx;
  logic          o_busy;
  logic [7:0]    o_word_count;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            pops = 0;
  int            pop_cyc[$];
  logic [DW-1:0] fifo_q[$];

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_enable      (i_enable),
    .i_fifo_data   (i_fifo_data),
    .i_fifo_empty  (i_fifo_empty),
    .o_fifo_rd_stb (o_fifo_rd_stb),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_word_count  (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Cycle counter used to time pop strobes.
  always @(posedge i_clk) cyc <= cyc + 1;

  // Record every pop strobe seen mid-cycle.
  always @(negedge i_clk) begin
    if (o_fifo_rd_stb) begin
      pops = pops + 1;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    if (fifo_q.size() > 0) begin
      i_fifo_data  = fifo_q[0];
      i_fifo_empty = 1'b0;
    end else begin
      i_fifo_data  = '0;
      i_fifo_empty = 1'b1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Expected line level in frame slot s of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    else if (s <= 8) return b[s-1];
`ifdef FIFO_UART_TX_PARITY_EN
    else if (s == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Called at a negedge: wait for the pop, then check every cycle of the word.
  task automatic check_word(input logic [DW-1:0] w, input bit drop_en, input bit push_mid,
                            input logic [DW-1:0] mid_w, input logic [7:0] exp_cnt);
    int n;
    logic [7:0] b;
    n = 0;
    while (!o_fifo_rd_stb && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check_val("pop_seen", o_fifo_rd_stb, 1'b1);
    if (o_fifo_rd_stb) begin
      @(posedge i_clk);
      #1;
      void'(fifo_q.pop_front());
      refresh();
    end
    for (int by = 0; by < 2; by++) begin
      b = w[by*8 +: 8];
      for (int s = 0; s < F; s++) begin
        for (int c = 0; c < CPB; c++) begin
          if (push_mid && by == 0 && s == 3 && c == 0) push(mid_w);
          if (drop_en && by == 1 && s == 0 && c == 0) i_enable = 1'b0;
          @(negedge i_clk);
          check_val($sformatf("tx w%0h b%0d s%0d c%0d", w, by, s, c), o_tx, exp_bit(b, s));
          if (c == 0) begin
            check_val($sformatf("busy w%0h b%0d s%0d", w, by, s), o_busy, 1'b1);
            check_val($sformatf("no_stb w%0h b%0d s%0d", w, by, s), o_fifo_rd_stb, 1'b0);
          end
        end
      end
    end
    @(negedge i_clk);
    check_val("idle_busy", o_busy, 1'b0);
    check_val("idle_tx", o_tx, 1'b1);
    check_val("word_count", o_word_count, exp_cnt);
    if (!i_enable) check_val("stb_while_disabled", o_fifo_rd_stb, 1'b0);
  endtask

  initial begin
    int base;
    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    refresh();

    // Reset held with a non-empty FIFO: line idle, no pop, counters zero.
    push(16'hA55A);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check_val("rst_tx", o_tx, 1'b1);
      check_val("rst_stb", o_fifo_rd_stb, 1'b0);
      check_val("rst_busy", o_busy, 1'b0);
      check_val("rst_cnt", o_word_count, 8'd0);
    end
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);

    // Single word 0xA55A: byte 0x5A then 0xA5.
    check_word(16'hA55A, 1'b0, 1'b0, 16'h0000, 8'd1);
    repeat (40) @(negedge i_clk);
    check_val("single_pops", pops, 1);

    // Fresh count, then three back-to-back words.
    @(posedge i_clk);
    #1 i_reset_n = 1'b0;
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    base = pops;
    push(16'h1234);
    push(16'h00FF);
    push(16'h8001);
    @(negedge i_clk);
    check_word(16'h1234, 1'b0, 1'b0, 16'h0000, 8'd1);
    check_word(16'h00FF, 1'b0, 1'b0, 16'h0000, 8'd2);
    check_word(16'h8001, 1'b0, 1'b0, 16'h0000, 8'd3);
    repeat (200) @(negedge i_clk);
    check_val("b2b_pops", pops - base, 3);
    check_val("pitch_1", pop_cyc[base+1] - pop_cyc[base], PITCH);
    check_val("pitch_2", pop_cyc[base+2] - pop_cyc[base+1], PITCH);
    check_val("b2b_cnt", o_word_count, 8'd3);

    // Enable dropped in byte 1; a word written mid-frame waits for re-enable.
    @(posedge i_clk);
    #1 push(16'h3C96);
    base = pops;
    @(negedge i_clk);
    check_word(16'h3C96, 1'b1, 1'b1, 16'h5AA5, 8'd4);
    repeat (30) @(negedge i_clk);
    check_val("disabled_pops", pops - base, 1);
    check_val("disabled_busy", o_busy, 1'b0);
    @(posedge i_clk);
    #1 i_enable = 1'b1;
    @(negedge i_clk);
    check_word(16'h5AA5, 1'b0, 1'b0, 16'h0000, 8'd5);

    // Reset in the middle of a data bit: word 0x1100 is lost, 0x0F0F follows intact.
    @(posedge i_clk);
    #1;
    push(16'h1100);
    push(16'h0F0F);
    @(negedge i_clk);
    check_val("mid_pop", o_fifo_rd_stb, 1'b1);
    @(posedge i_clk);
    #1;
    void'(fifo_q.pop_front());
    refresh();
    repeat (14) @(negedge i_clk);
    check_val("mid_tx_low", o_tx, 1'b0);
    #1 i_reset_n = 1'b0;
    #1;
    check_val("mid_rst_tx", o_tx, 1'b1);
    check_val("mid_rst_busy", o_busy, 1'b0);
    check_val("mid_rst_cnt", o_word_count, 8'd0);
    check_val("mid_rst_stb", o_fifo_rd_stb, 1'b0);
    repeat (3) begin
      @(negedge i_clk);
      check_val("mid_hold_stb", o_fifo_rd_stb, 1'b0);
    end
    @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    check_word(16'h0F0F, 1'b0, 1'b0, 16'h0000, 8'd1);
    repeat (20) @(negedge i_clk);
    check_val("total_pops", pops, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
